dbus_arbiter: RTL and testbench
===============================

// Module: dbus_arbiter
// PURPOSE
//  Data-bus arbiter between N DBus masters (CPU at index 0, DMA/debug at higher indices) and a single
//  DBus slave fabric. Masters raise Req in their E stage; grant is registered and visible in their M
//  stage (address phase). Routes the owner's command to the slave, returns read data and WaitReq in the
//  following data phase (CPU W stage). Round-robin fairness; slave stalls are never split across owners.
// PARAMETERS
//  p_NUM_MASTERS  2   number of masters, 2..8
//  p_ADDR_W       30  word address width
//  p_DATA_W       32  data width; ByteEn width = p_DATA_W/8
//  p_HOLD_MAX     16  max consecutive owned cycles while others wait (only with DBUS_ARB_HOLD_LIMIT_EN)
// PORTS
//  i_Clk          in   1                 clock, all state on rising edge
//  i_Rst_n        in   1                 asynchronous active-low reset
//  i_Req          in   N                 per-master bus request (E stage)
//  o_Gnt          out  N                 one-hot registered grant (M stage), all-zero when idle
//  i_M_Address    in   N*p_ADDR_W        packed master addresses, master m at [m*p_ADDR_W +: p_ADDR_W]
//  i_M_ByteEn     in   N*p_DATA_W/8      packed byte enables
//  i_M_Read       in   N                 read command
//  i_M_Write      in   N                 write command
//  i_M_WriteData  in   N*p_DATA_W        packed write data
//  o_M_ReadData   out  p_DATA_W          slave read data, broadcast to all masters
//  o_M_WaitReq    out  N                 data-phase stall, asserted only to the data-phase owner
//  o_S_Address    out  p_ADDR_W          slave address (owner's, else 0)
//  o_S_ByteEn     out  p_DATA_W/8        slave byte enables
//  o_S_Read       out  1                 slave read strobe
//  o_S_Write      out  1                 slave write strobe
//  o_S_WriteData  out  p_DATA_W          slave write data
//  i_S_ReadData   in   p_DATA_W          slave read data, valid in data phase when !i_S_WaitReq
//  i_S_WaitReq    in   1                 slave stall, meaningful only in data phase
// BEHAVIOUR
//  - Reset: o_Gnt=0, all o_S_* =0, o_M_WaitReq=0, state IDLE, RR pointer=N-1 (master 0 wins first), hold cnt=0.
//  - States: IDLE (no owner), OWNED (owner may issue), STALL (data phase held by i_S_WaitReq).
//  - Address phase: in OWNED, o_S_* = owner's i_M_* combinationally; non-owner Read/Write ignored.
//  - Command issued at edge when o_S_Read|o_S_Write: r_DataOwner<=owner, r_DataActive<=1.
//  - Data phase: o_M_ReadData=i_S_ReadData; o_M_WaitReq[r_DataOwner]=i_S_WaitReq&r_DataActive, others 0.
//    If i_S_WaitReq: STALL; o_S_Read/o_S_Write forced 0 (owner's new command not forwarded); o_Gnt held.
//    If !i_S_WaitReq: data phase retires; owner's command in same cycle forwarded (back-to-back, 1/clk).
//  - Release: at edge, not STALL, owner's i_Req low -> owner released; re-arbitrate same edge.
//  - Arbitration: search i_Req from pointer+1 upward, wrap at N-1->0; first set bit gets o_Gnt next cycle,
//    pointer<=winner. No requester -> IDLE, o_Gnt=0. Idle->grant latency exactly 1 clock.
//  - Owner holding i_Req keeps bus (locked sequences); simultaneous release+new requests resolved by RR.
//  - Release during STALL impossible: deferred until the edge where i_S_WaitReq is low.
//  - Reset asserted mid-transfer: immediate return to reset values; in-flight data phase abandoned.
// CONFIGURATION
//  DBUS_ARB_HOLD_LIMIT_EN defined: counter counts owned non-STALL cycles while any other i_Req set;
//   at count==p_HOLD_MAX owner forcibly released at next non-STALL edge, RR selects next; count clears on
//   grant change or when no other request. Undefined: no counter, owner keeps bus while i_Req high.
// TESTING
//  1 Reset: i_Rst_n=0 mid-STALL -> o_Gnt=00, o_S_Read=0, o_M_WaitReq=00 same cycle; master 0 first after release.
//  2 Single read: i_Req=01 @c0 -> o_Gnt=01 @c1; M0 Read 0x100 @c1 -> o_S_Address=0x100,o_S_Read=1 @c1;
//    i_S_ReadData=0xDEADBEEF @c2 -> o_M_ReadData=0xDEADBEEF, o_M_WaitReq=00.
//  3 Contention: i_Req=11 from IDLE -> o_Gnt=01; M0 drops Req -> o_Gnt=10 next cycle; both re-request
//    -> grants alternate 01,10,01 on each release.
//  4 Stall: M0 write, i_S_WaitReq=1 for 3 data cycles, M0 Req low, M1 Req high -> o_M_WaitReq=01 x3,
//    o_S_Write=0 during, o_Gnt=01 held; o_Gnt=10 the cycle after WaitReq falls.
//  5 Back-to-back: M0 reads 0x10,0x14,0x18 on consecutive cycles, no stall -> 3 slave reads in 3 cycles, 3 data returns.
//  6 DBUS_ARB_HOLD_LIMIT_EN, p_HOLD_MAX=4: M0 Req held, M1 Req high -> o_Gnt=10 after 4 owned cycles;
//    without macro o_Gnt stays 01 for 100 cycles.

Source files
------------

// File: rtl/dbus_arbiter.sv
// Round-robin data-bus arbiter: N masters share one slave, and a stalled data phase keeps the grant on its owner.
// Define DBUS_ARB_HOLD_LIMIT_EN to cap how long an owner can hold the bus while other masters are waiting.
module dbus_arbiter #(
  parameter int p_NUM_MASTERS = 2,
  parameter int p_ADDR_W      = 30,
  parameter int p_DATA_W      = 32,
  parameter int p_HOLD_MAX    = 16
) (
  input  logic                                  i_Clk,
  input  logic                                  i_Rst_n,
  input  logic [p_NUM_MASTERS-1:0]              i_Req,
  output logic [p_NUM_MASTERS-1:0]              o_Gnt,
  input  logic [p_NUM_MASTERS*p_ADDR_W-1:0]     i_M_Address,
  input  logic [p_NUM_MASTERS*(p_DATA_W/8)-1:0] i_M_ByteEn,
  input  logic [p_NUM_MASTERS-1:0]              i_M_Read,
  input  logic [p_NUM_MASTERS-1:0]              i_M_Write,
  input  logic [p_NUM_MASTERS*p_DATA_W-1:0]     i_M_WriteData,
  output logic [p_DATA_W-1:0]                   o_M_ReadData,
  output logic [p_NUM_MASTERS-1:0]              o_M_WaitReq,
  output logic [p_ADDR_W-1:0]                   o_S_Address,
  output logic [p_DATA_W/8-1:0]                 o_S_ByteEn,
  output logic                                  o_S_Read,
  output logic                                  o_S_Write,
  output logic [p_DATA_W-1:0]                   o_S_WriteData,
  input  logic [p_DATA_W-1:0]                   i_S_ReadData,
  input  logic                                  i_S_WaitReq
);

  localparam int N    = p_NUM_MASTERS;
  localparam int BE_W = p_DATA_W / 8;
  localparam int OW   = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, OWNED, STALL} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [OW-1:0]  owner_q, owner_d;
  logic [OW-1:0]  ptr_q, ptr_d;
  logic [OW-1:0]  data_owner_q, data_owner_d;
  logic           data_active_q, data_active_d;

  logic [p_ADDR_W-1:0] m_addr  [N];
  logic [BE_W-1:0]     m_be    [N];
  logic [p_DATA_W-1:0] m_wdata [N];

  logic          owned;
  logic          stall;
  logic          keep;
  logic          hold_expire;
  logic          arb_found;
  logic [OW-1:0] arb_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_master
      assign m_addr[gi]      = i_M_Address[gi*p_ADDR_W +: p_ADDR_W];
      assign m_be[gi]        = i_M_ByteEn[gi*BE_W +: BE_W];
      assign m_wdata[gi]     = i_M_WriteData[gi*p_DATA_W +: p_DATA_W];
      assign o_M_WaitReq[gi] = data_active_q & i_S_WaitReq & (data_owner_q == OW'(gi));
    end
  endgenerate

  assign owned        = (state_q != IDLE);
  assign stall        = data_active_q & i_S_WaitReq;
  assign o_Gnt        = gnt_q;
  assign o_M_ReadData = i_S_ReadData;

  // Address phase: only the owner's command reaches the slave, and nothing new issues while the slave stalls.
  always_comb begin
    o_S_Address   = '0;
    o_S_ByteEn    = '0;
    o_S_WriteData = '0;
    o_S_Read      = 1'b0;
    o_S_Write     = 1'b0;
    if (owned) begin
      o_S_Address   = m_addr[owner_q];
      o_S_ByteEn    = m_be[owner_q];
      o_S_WriteData = m_wdata[owner_q];
      o_S_Read      = i_M_Read[owner_q] & ~stall;
      o_S_Write     = i_M_Write[owner_q] & ~stall;
    end
  end

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr_q;
    for (int k = 1; k <= N; k++) begin
      if (!arb_found && i_Req[(int'(ptr_q) + k) % N]) begin
        arb_found = 1'b1;
        arb_idx   = OW'((int'(ptr_q) + k) % N);
      end
    end
  end

`ifdef DBUS_ARB_HOLD_LIMIT_EN
  localparam int CW = $clog2(p_HOLD_MAX + 1);
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          others_req;

  assign others_req  = |(i_Req & ~gnt_q);
  // Expires on the edge that would complete the p_HOLD_MAX-th contended owned cycle.
  assign hold_expire = owned & others_req & (int'(hold_cnt_q) >= p_HOLD_MAX - 1);

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if ((gnt_d != gnt_q) || !others_req) begin
      hold_cnt_d = '0;
    end else if (owned && !stall) begin
      hold_cnt_d = hold_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign hold_expire = 1'b0;
`endif

  assign keep = owned & i_Req[owner_q] & ~hold_expire;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (stall) begin
      // A stalled data phase pins the grant, so one transfer never spans two owners.
      state_d = owned ? STALL : IDLE;
    end else if (keep) begin
      state_d = OWNED;
    end else if (arb_found) begin
      state_d        = OWNED;
      owner_d        = arb_idx;
      ptr_d          = arb_idx;
      gnt_d          = '0;
      gnt_d[arb_idx] = 1'b1;
    end else begin
      state_d = IDLE;
      gnt_d   = '0;
    end
  end

  always_comb begin
    data_owner_d  = data_owner_q;
    data_active_d = stall;
    if (o_S_Read || o_S_Write) begin
      data_owner_d  = owner_q;
      data_active_d = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      owner_q       <= '0;
      ptr_q         <= OW'(N - 1);
      data_owner_q  <= '0;
      data_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      data_owner_q  <= data_owner_d;
      data_active_q <= data_active_d;
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed testbench for dbus_arbiter (two masters): reset, single read, contention, stall, back-to-back, hold limit.
module tb_dbus_arbiter;

  localparam int N    = 2;
  localparam int AW   = 30;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int HOLD = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N-1:0]      gnt;
  logic [AW-1:0]     m_addr  [N];
  logic [BW-1:0]     m_be    [N];
  logic [DW-1:0]     m_wdata [N];
  logic [N-1:0]      m_rd;
  logic [N-1:0]      m_wr;
  logic [N*AW-1:0]   addr_bus;
  logic [N*BW-1:0]   be_bus;
  logic [N*DW-1:0]   wdata_bus;
  logic [DW-1:0]     m_rdata;
  logic [N-1:0]      m_wait;
  logic [AW-1:0]     s_addr;
  logic [BW-1:0]     s_be;
  logic              s_rd;
  logic              s_wr;
  logic [DW-1:0]     s_wdata;
  logic [DW-1:0]     s_rdata;
  logic              s_wait;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign addr_bus  = {m_addr[1], m_addr[0]};
  assign be_bus    = {m_be[1], m_be[0]};
  assign wdata_bus = {m_wdata[1], m_wdata[0]};

  dbus_arbiter #(
    .p_NUM_MASTERS(N),
    .p_ADDR_W(AW),
    .p_DATA_W(DW),
    .p_HOLD_MAX(HOLD)
  ) dut (
    .i_Clk(clk),
    .i_Rst_n(rst_n),
    .i_Req(req),
    .o_Gnt(gnt),
    .i_M_Address(addr_bus),
    .i_M_ByteEn(be_bus),
    .i_M_Read(m_rd),
    .i_M_Write(m_wr),
    .i_M_WriteData(wdata_bus),
    .o_M_ReadData(m_rdata),
    .o_M_WaitReq(m_wait),
    .o_S_Address(s_addr),
    .o_S_ByteEn(s_be),
    .o_S_Read(s_rd),
    .o_S_Write(s_wr),
    .o_S_WriteData(s_wdata),
    .i_S_ReadData(s_rdata),
    .i_S_WaitReq(s_wait)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    req     = '0;
    m_rd    = '0;
    m_wr    = '0;
    s_rdata = '0;
    s_wait  = 1'b0;
    for (int m = 0; m < N; m++) begin
      m_addr[m]  = '0;
      m_be[m]    = '0;
      m_wdata[m] = '0;
    end
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    settle();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();

    // Reset state
    reset_dut();
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_s_rd", 64'(s_rd), 64'h0);
    check("rst_s_wr", 64'(s_wr), 64'h0);
    check("rst_s_addr", 64'(s_addr), 64'h0);
    check("rst_m_wait", 64'(m_wait), 64'h0);
    $display("reset: gnt=%b s_rd=%b m_wait=%b", gnt, s_rd, m_wait);

    // Single read
    req = 2'b01;
    tick();
    check("rd_gnt", 64'(gnt), 64'h1);
    m_rd[0] = 1'b1; m_addr[0] = 30'h100; m_be[0] = 4'hF;
    m_rd[1] = 1'b1; m_addr[1] = 30'h3AA;
    settle();
    check("rd_s_addr", 64'(s_addr), 64'h100);
    check("rd_s_rd", 64'(s_rd), 64'h1);
    check("rd_s_be", 64'(s_be), 64'hF);
    tick();
    m_rd = '0; req = 2'b00;
    s_rdata = 32'hDEADBEEF;
    settle();
    check("rd_m_rdata", 64'(m_rdata), 64'hDEADBEEF);
    check("rd_m_wait", 64'(m_wait), 64'h0);
    check("rd_s_rd_idle", 64'(s_rd), 64'h0);
    tick();
    check("rd_release_gnt", 64'(gnt), 64'h0);
    $display("single read: s_addr=0x100 rdata=%h", m_rdata);

    // Contention and round-robin
    reset_dut();
    req = 2'b11;
    tick();
    check("rr_first_gnt", 64'(gnt), 64'h1);
    tick();
    check("rr_owner_keeps", 64'(gnt), 64'h1);
    req = 2'b10;
    tick();
    check("rr_to_m1", 64'(gnt), 64'h2);
    req = 2'b01;
    tick();
    check("rr_to_m0", 64'(gnt), 64'h1);
    req = 2'b10;
    tick();
    check("rr_to_m1_again", 64'(gnt), 64'h2);
    req = 2'b00;
    tick();
    check("rr_idle", 64'(gnt), 64'h0);
    req = 2'b11;
    tick();
    check("rr_ptr_after_m1", 64'(gnt), 64'h1);
    $display("contention: grants alternated 01,10,01,10");

    // Stall: write held by slave, grant must not move until the data phase retires
    reset_dut();
    req = 2'b01;
    tick();
    m_wr[0] = 1'b1; m_addr[0] = 30'h200; m_wdata[0] = 32'hCAFE0001; m_be[0] = 4'h3;
    settle();
    check("st_s_wr", 64'(s_wr), 64'h1);
    check("st_s_wdata", 64'(s_wdata), 64'hCAFE0001);
    tick();
    req = 2'b10; s_wait = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("st_m_wait", 64'(m_wait), 64'h1);
      check("st_s_wr_gated", 64'(s_wr), 64'h0);
      check("st_gnt_held", 64'(gnt), 64'h1);
      tick();
    end
    s_wait = 1'b0; m_wr = '0;
    settle();
    check("st_m_wait_done", 64'(m_wait), 64'h0);
    check("st_gnt_last", 64'(gnt), 64'h1);
    tick();
    check("st_gnt_m1", 64'(gnt), 64'h2);
    $display("stall: 3 wait cycles then gnt=%b", gnt);

    // Back-to-back reads
    reset_dut();
    req = 2'b01;
    tick();
    m_rd[0] = 1'b1; m_addr[0] = 30'h10;
    settle();
    check("b2b_addr0", 64'(s_addr), 64'h10);
    check("b2b_rd0", 64'(s_rd), 64'h1);
    tick();
    m_addr[0] = 30'h14; s_rdata = 32'h11110000;
    settle();
    check("b2b_addr1", 64'(s_addr), 64'h14);
    check("b2b_rd1", 64'(s_rd), 64'h1);
    check("b2b_data0", 64'(m_rdata), 64'h11110000);
    check("b2b_wait0", 64'(m_wait), 64'h0);
    tick();
    m_addr[0] = 30'h18; s_rdata = 32'h22220000;
    settle();
    check("b2b_addr2", 64'(s_addr), 64'h18);
    check("b2b_rd2", 64'(s_rd), 64'h1);
    check("b2b_data1", 64'(m_rdata), 64'h22220000);
    tick();
    m_rd = '0; s_rdata = 32'h33330000;
    settle();
    check("b2b_rd_off", 64'(s_rd), 64'h0);
    check("b2b_data2", 64'(m_rdata), 64'h33330000);
    check("b2b_wait2", 64'(m_wait), 64'h0);
    $display("back-to-back: reads 0x10,0x14,0x18 returned");

    // Reset asserted mid-stall
    reset_dut();
    req = 2'b01;
    tick();
    m_rd[0] = 1'b1; m_addr[0] = 30'h40;
    tick();
    s_wait = 1'b1;
    settle();
    check("mrst_wait_pre", 64'(m_wait), 64'h1);
    rst_n = 1'b0;
    settle();
    check("mrst_gnt", 64'(gnt), 64'h0);
    check("mrst_s_rd", 64'(s_rd), 64'h0);
    check("mrst_m_wait", 64'(m_wait), 64'h0);
    tick();
    clear_inputs();
    rst_n = 1'b1;
    req = 2'b11;
    tick();
    check("mrst_first_m0", 64'(gnt), 64'h1);
    $display("mid-stall reset: gnt cleared, master 0 first after release");

    // Hold behaviour with a competing request
    reset_dut();
    req = 2'b11;
    tick();
`ifdef DBUS_ARB_HOLD_LIMIT_EN
    for (int c = 0; c < HOLD; c++) begin
      check("hold_owned", 64'(gnt), 64'h1);
      tick();
    end
    check("hold_forced", 64'(gnt), 64'h2);
    $display("hold limit: gnt moved to master 1 after %0d cycles", HOLD);
`else
    for (int c = 0; c < 100; c++) begin
      check("hold_kept", 64'(gnt), 64'h1);
      tick();
    end
    $display("no hold limit: master 0 kept the bus for 100 cycles");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
